// File: rtl/rob_pkg.sv
// rob_pkg: shared sizes, entry type codes and the entry record for the
// reorder buffer.
//   ROB_WIDTH / ROB_WIDTH_BIT : entry count (power of two) and tag width
//   REG_ID_BIT                : architectural register index width
//   rob_type_e                : REG, BRANCH, STORE, JALR entry kinds
//   rob_entry_t               : one stored reorder-buffer entry
package rob_pkg;

  localparam int ROB_WIDTH     = 8;
  localparam int ROB_WIDTH_BIT = 3;
  localparam int REG_ID_BIT    = 5;

  // count must hold ROB_WIDTH itself, hence one extra bit
  localparam int CNT_W = ROB_WIDTH_BIT + 1;
  localparam logic [CNT_W-1:0] ROB_FULL_COUNT = CNT_W'(ROB_WIDTH);

  typedef enum logic [1:0] {
    ROB_REG    = 2'd0,
    ROB_BRANCH = 2'd1,
    ROB_STORE  = 2'd2,
    ROB_JALR   = 2'd3
  } rob_type_e;

  typedef struct packed {
    logic                  busy;
    logic                  ready;
    rob_type_e             kind;
    logic [REG_ID_BIT-1:0] rd;
    logic [31:0]           value;
    logic [31:0]           pc;
    logic                  pred;
    logic [31:0]           target;
  } rob_entry_t;

endpackage

// File: rtl/rob.sv
// rob: in-order reorder buffer between the decoder, the reservation station
// and the load/store buffer.
//   clk_in, rst_in (async, active-low), rdy_in (pause when low)
//   allocation : to_rob, type_in, rd_in, pc_in, pred_taken_in, br_target_in;
//                rob_full, alloc_id (tag handed to the new instruction)
//   writeback  : rs_to_rob/rs_rob_id/rs_value, lsb_to_rob/lsb_rob_id/lsb_value
//   query      : qry_{j,k}_id -> qry_{j,k}_ready, qry_{j,k}_value (combinational)
//   retire     : commit_reg, commit_rd, commit_value, commit_id, commit_store
//   redirect   : flush, flush_pc (one-cycle mispredict pulse)
//   debug      : dbg_count (number of occupied entries)
//
// Handshake: to_rob is a valid strobe and !rob_full is its ready; an entry is
// allocated only on an edge where both are high (and rdy_in is high). The
// writeback ports are valid-only and always accepted; a writeback whose tag
// names a non-busy entry is dropped.
module rob
  import rob_pkg::*;
(
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,

  output logic                     rob_full,
  output logic [ROB_WIDTH_BIT-1:0] alloc_id,
  input  logic                     to_rob,
  input  logic [1:0]               type_in,
  input  logic [REG_ID_BIT-1:0]    rd_in,
  input  logic [31:0]              pc_in,
  input  logic                     pred_taken_in,
  input  logic [31:0]              br_target_in,

  input  logic                     rs_to_rob,
  input  logic [ROB_WIDTH_BIT-1:0] rs_rob_id,
  input  logic [31:0]              rs_value,
  input  logic                     lsb_to_rob,
  input  logic [ROB_WIDTH_BIT-1:0] lsb_rob_id,
  input  logic [31:0]              lsb_value,

  input  logic [ROB_WIDTH_BIT-1:0] qry_j_id,
  input  logic [ROB_WIDTH_BIT-1:0] qry_k_id,
  output logic                     qry_j_ready,
  output logic                     qry_k_ready,
  output logic [31:0]              qry_j_value,
  output logic [31:0]              qry_k_value,

  output logic                     commit_reg,
  output logic [REG_ID_BIT-1:0]    commit_rd,
  output logic [31:0]              commit_value,
  output logic [ROB_WIDTH_BIT-1:0] commit_id,
  output logic                     commit_store,
  output logic                     flush,
  output logic [31:0]              flush_pc,

  output logic [CNT_W-1:0]         dbg_count
);

  rob_entry_t               entries [ROB_WIDTH];
  logic [ROB_WIDTH_BIT-1:0] head;
  logic [ROB_WIDTH_BIT-1:0] tail;
  logic [CNT_W-1:0]         count;

  // Pulse registers; the outputs are masked by rdy_in so a pulse produced
  // just before a pause is held and shown once the pause ends.
  logic commit_reg_q;
  logic commit_store_q;
  logic flush_q;

  rob_entry_t head_e;
  logic       do_commit;
  logic       do_alloc;
  logic       actual_taken;

  assign head_e       = entries[head];
  // Commit looks only at the registered ready bit, so an entry is never
  // written back and retired on the same edge.
  assign do_commit    = head_e.busy & head_e.ready;
  assign do_alloc     = to_rob & ~rob_full;
  assign actual_taken = head_e.value[0];

  assign rob_full  = (count == ROB_FULL_COUNT);
  assign alloc_id  = tail;
  assign dbg_count = count;

  assign qry_j_ready = entries[qry_j_id].busy & entries[qry_j_id].ready;
  assign qry_k_ready = entries[qry_k_id].busy & entries[qry_k_id].ready;
  assign qry_j_value = entries[qry_j_id].value;
  assign qry_k_value = entries[qry_k_id].value;

  assign commit_reg   = commit_reg_q & rdy_in;
  assign commit_store = commit_store_q & rdy_in;
  assign flush        = flush_q & rdy_in;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < ROB_WIDTH; i++) begin
        entries[i] <= '0;
      end
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      commit_reg_q   <= 1'b0;
      commit_store_q <= 1'b0;
      flush_q        <= 1'b0;
      commit_rd      <= '0;
      commit_value   <= '0;
      commit_id      <= '0;
      flush_pc       <= '0;
    end else if (rdy_in) begin
      commit_reg_q   <= 1'b0;
      commit_store_q <= 1'b0;
      flush_q        <= 1'b0;

      if (flush_q) begin
        // Mispredict cycle: drop everything younger than the branch, ignoring
        // any allocation or writeback presented in this cycle.
        for (int i = 0; i < ROB_WIDTH; i++) begin
          entries[i].busy  <= 1'b0;
          entries[i].ready <= 1'b0;
        end
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        // LSB writeback is applied after the RS one so it wins a tag clash.
        if (rs_to_rob && entries[rs_rob_id].busy) begin
          entries[rs_rob_id].ready <= 1'b1;
          entries[rs_rob_id].value <= rs_value;
        end
        if (lsb_to_rob && entries[lsb_rob_id].busy) begin
          entries[lsb_rob_id].ready <= 1'b1;
          entries[lsb_rob_id].value <= lsb_value;
        end

        if (do_commit) begin
          entries[head].busy  <= 1'b0;
          entries[head].ready <= 1'b0;
          head                <= head + 1'b1;
          commit_id           <= head;
          commit_rd           <= head_e.rd;
          commit_value        <= head_e.value;
          case (head_e.kind)
            ROB_REG, ROB_JALR: commit_reg_q   <= 1'b1;
            ROB_STORE:         commit_store_q <= 1'b1;
            ROB_BRANCH: begin
              if (actual_taken != head_e.pred) begin
                flush_q  <= 1'b1;
                flush_pc <= actual_taken ? head_e.target : head_e.pc + 32'd4;
              end
            end
            default: ;
          endcase
        end

        // When the buffer is empty the head is not busy, and when it is full
        // do_alloc is low, so this never collides with the commit above.
        if (do_alloc) begin
          entries[tail] <= '{busy:   1'b1,
                             ready:  1'b0,
                             kind:   rob_type_e'(type_in),
                             rd:     rd_in,
                             value:  32'd0,
                             pc:     pc_in,
                             pred:   pred_taken_in,
                             target: br_target_in};
          tail <= tail + 1'b1;
        end

        case ({do_alloc, do_commit})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule
